// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and round-robin auto-scan.
// Adds clock enable, channel tag, valid flag and an end-of-sweep wrap pulse.
module mux_scan #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      ch,
  output logic                  valid,
  output logic                  wrap
);

  localparam int unsigned DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned LAST_CH = N_CH - 1;
  localparam int unsigned LAST_DW = DWELL - 1;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             mode_q, mode_d;

  logic [WIDTH-1:0] y_d;
  logic [SEL_W-1:0] ch_d;
  logic             valid_d;
  logic             wrap_d;

  logic [SEL_W-1:0] p;
  logic [DW_W-1:0]  d;
  logic             sel_ok;

  // Decoded channel read; only legal indices ever match, so no out-of-range slice.
  function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] din_v,
                                            input logic [SEL_W-1:0]      idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = din_v[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      ch      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      ptr_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      y       <= y_d;
      ch      <= ch_d;
      valid   <= valid_d;
      wrap    <= wrap_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state: manual select or scan step on enabled edges, freeze otherwise
  always_comb begin
    y_d     = y;
    ch_d    = ch;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    p       = ptr_q;
    d       = dwell_q;

    if (en) begin
      mode_d = mode;
      if (!mode) begin
        ch_d    = sel;
        dwell_d = '0;
        if (sel_ok) begin
          y_d     = pick(din, sel);
          valid_d = 1'b1;
        end else begin
          y_d = '0;
        end
      end else begin
        // Entering auto restarts the sweep from sel (or ch0 when sel is illegal)
        if (!mode_q) begin
          p = sel_ok ? sel : '0;
          d = '0;
        end
        y_d     = pick(din, p);
        ch_d    = p;
        valid_d = 1'b1;
        if (d == DW_W'(LAST_DW)) begin
          dwell_d = '0;
          ptr_d   = (p == SEL_W'(LAST_CH)) ? '0 : p + SEL_W'(1);
          wrap_d  = (p == SEL_W'(LAST_CH));
        end else begin
          dwell_d = d + DW_W'(1);
          ptr_d   = p;
        end
      end
    end
  end

endmodule
